// File: rtl/simd_sub_seq.sv
// Sequential packed-SIMD subtractor: c = a - b per 8/16/32-bit lane, one byte per cycle.
// Optional unsigned mode (extra `uns` port) is enabled by defining SIMD_SUB_UNSIGNED_EN.
module simd_sub_seq #(
  parameter int BYTE_W = 8,
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  input  logic [1:0]                 width,
  input  logic                       saturate,
`ifdef SIMD_SUB_UNSIGNED_EN
  input  logic                       uns,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BYTE_W*NBYTES-1:0]   c,
  output logic [NBYTES-1:0]          ovf
);

  localparam int KW = $clog2(NBYTES);
  localparam int DW = BYTE_W * NBYTES;
  localparam logic [KW-1:0] LAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        a_q, b_q;
  logic [1:0]           width_q;
  logic                 sat_q;
  logic [KW-1:0]        byteIdx_q;
  logic                 borrow_q;
  logic [DW-1:0]        accRes_q, accRes_d;
  logic [NBYTES-1:0]    accOvf_q, accOvf_d;
  logic [DW-1:0]        satRes_d;
  logic [DW-1:0]        cOut_q;
  logic [NBYTES-1:0]    ovfOut_q;
  logic                 unsMode;

  logic [BYTE_W-1:0]    aByte, bByte;
  logic [BYTE_W:0]      diff9;
  logic                 borrowIn;
  logic                 laneOvf;
  logic [NBYTES-1:0]    signA;
  logic [KW-1:0]        topIdx;

`ifdef SIMD_SUB_UNSIGNED_EN
  logic uns_q;
  assign unsMode = uns_q;
`else
  assign unsMode = 1'b0;
`endif

  // Index of the most significant byte of the lane that contains byte idx.
  function automatic logic [KW-1:0] laneTop(input logic [KW-1:0] idx, input logic [1:0] w);
    case (w)
      2'b00:   laneTop = idx;
      2'b01:   laneTop = idx | KW'(1);
      default: laneTop = LAST;
    endcase
  endfunction

  function automatic logic laneStart(input logic [KW-1:0] idx, input logic [1:0] w);
    case (w)
      2'b00:   laneStart = 1'b1;
      2'b01:   laneStart = ~idx[0];
      default: laneStart = (idx == '0);
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (byteIdx_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aByte = '0;
    bByte = '0;
    signA = '0;
    for (int j = 0; j < NBYTES; j++) begin
      signA[j] = a_q[j*BYTE_W + BYTE_W - 1];
      if (byteIdx_q == KW'(j)) begin
        aByte = a_q[j*BYTE_W +: BYTE_W];
        bByte = b_q[j*BYTE_W +: BYTE_W];
      end
    end
    borrowIn = laneStart(byteIdx_q, width_q) ? 1'b0 : borrow_q;
    diff9    = {1'b0, aByte} - {1'b0, bByte} - {{BYTE_W{1'b0}}, borrowIn};
    laneOvf  = unsMode ? diff9[BYTE_W]
                       : ((aByte[BYTE_W-1] != bByte[BYTE_W-1]) &&
                          (diff9[BYTE_W-1] != aByte[BYTE_W-1]));

    accRes_d = accRes_q;
    accOvf_d = accOvf_q;
    for (int j = 0; j < NBYTES; j++) begin
      if (byteIdx_q == KW'(j)) begin
        accRes_d[j*BYTE_W +: BYTE_W] = diff9[BYTE_W-1:0];
        if (laneTop(byteIdx_q, width_q) == byteIdx_q) accOvf_d[j] = laneOvf;
      end
    end

    // Clamp each byte of an overflowed lane; only the lane's top byte carries the sign bit.
    satRes_d = accRes_d;
    topIdx   = '0;
    for (int j = 0; j < NBYTES; j++) begin
      topIdx = laneTop(KW'(j), width_q);
      if (sat_q && accOvf_d[topIdx]) begin
        if (unsMode)
          satRes_d[j*BYTE_W +: BYTE_W] = '0;
        else if (signA[topIdx])
          satRes_d[j*BYTE_W +: BYTE_W] = (KW'(j) == topIdx) ? {1'b1, {(BYTE_W-1){1'b0}}} : '0;
        else
          satRes_d[j*BYTE_W +: BYTE_W] = (KW'(j) == topIdx) ? {1'b0, {(BYTE_W-1){1'b1}}} : '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      width_q   <= '0;
      sat_q     <= 1'b0;
      byteIdx_q <= '0;
      borrow_q  <= 1'b0;
      accRes_q  <= '0;
      accOvf_q  <= '0;
      cOut_q    <= '0;
      ovfOut_q  <= '0;
`ifdef SIMD_SUB_UNSIGNED_EN
      uns_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            width_q   <= width;
            sat_q     <= saturate;
            byteIdx_q <= '0;
            borrow_q  <= 1'b0;
            accRes_q  <= '0;
            accOvf_q  <= '0;
`ifdef SIMD_SUB_UNSIGNED_EN
            uns_q     <= uns;
`endif
          end
        end
        CALC: begin
          byteIdx_q <= byteIdx_q + KW'(1);
          borrow_q  <= diff9[BYTE_W];
          accRes_q  <= accRes_d;
          accOvf_q  <= accOvf_d;
          if (byteIdx_q == LAST) begin
            cOut_q   <= satRes_d;
            ovfOut_q <= accOvf_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign c   = cOut_q;
  assign ovf = ovfOut_q;

endmodule

// File: tb/tb_simd_sub_seq.sv
// Directed self-checking bench for simd_sub_seq (signed build) with hand-computed results.
module tb_simd_sub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  width;
  logic        saturate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [3:0]  ovf;
`ifdef SIMD_SUB_UNSIGNED_EN
  logic        uns;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  simd_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .width     (width),
    .saturate  (saturate),
`ifdef SIMD_SUB_UNSIGNED_EN
    .uns       (uns),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one operation, wait for the accept edge, then count edges until out_valid.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] tw,
                               input logic ts, output int latency);
    int waitCnt;
    @(negedge clk);
    a = ta; b = tb; width = tw; saturate = ts; in_valid = 1'b1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(waitCnt), 64'(0));
    @(posedge clk);
    #1 in_valid = 1'b0;
    latency = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic drainResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("drain_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; width = '0; saturate = 1'b0;
`ifdef SIMD_SUB_UNSIGNED_EN
    uns = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_c", 64'(c), 64'(0));
    checkOutput("rst_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h0510007F, 32'h01200180, 2'b00, 1'b0, lat);
    checkOutput("t1_latency", 64'(lat), 64'(4));
    checkOutput("t1_c", 64'(c), 64'h04F0FFFF);
    checkOutput("t1_ovf", 64'(ovf), 64'b0001);
    drainResult();

    applyStimulus(32'h0510007F, 32'h01200180, 2'b00, 1'b1, lat);
    checkOutput("t2_c", 64'(c), 64'h04F0FF7F);
    checkOutput("t2_ovf", 64'(ovf), 64'b0001);
    drainResult();

    applyStimulus(32'h80000000, 32'h00000001, 2'b10, 1'b0, lat);
    checkOutput("t3_c", 64'(c), 64'h7FFFFFFF);
    checkOutput("t3_ovf", 64'(ovf), 64'b1000);
    drainResult();

    applyStimulus(32'h80000000, 32'h00000001, 2'b11, 1'b1, lat);
    checkOutput("t3s_c", 64'(c), 64'h80000000);
    checkOutput("t3s_ovf", 64'(ovf), 64'b1000);
    drainResult();

    applyStimulus(32'h00000100, 32'h00010001, 2'b01, 1'b0, lat);
    checkOutput("t4_latency", 64'(lat), 64'(4));
    checkOutput("t4_c", 64'(c), 64'hFFFF00FF);
    checkOutput("t4_ovf", 64'(ovf), 64'b0000);

    // Hold off the consumer while a new operation is offered.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h12345678; width = 2'b10; saturate = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_c_hold", 64'(c), 64'hFFFF00FF);
      checkOutput("t5_ovf_hold", 64'(ovf), 64'b0000);
      checkOutput("t5_in_ready", 64'(in_ready), 64'(0));
      checkOutput("t5_out_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drainResult();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5_not_taken", 64'(out_valid), 64'(0));
    checkOutput("t5_c_kept", 64'(c), 64'hFFFF00FF);

    // Reset during the second CALC cycle discards the operation.
    @(negedge clk);
    a = 32'h7F7F7F7F; b = 32'h80808080; width = 2'b00; saturate = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_in_ready", 64'(in_ready), 64'(1));
    checkOutput("t6_out_valid", 64'(out_valid), 64'(0));
    checkOutput("t6_c", 64'(c), 64'(0));
    checkOutput("t6_ovf", 64'(ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(32'h7F7F7F7F, 32'h80808080, 2'b00, 1'b1, lat);
    checkOutput("t6_latency", 64'(lat), 64'(4));
    checkOutput("t6_fresh_c", 64'(c), 64'h7F7F7F7F);
    checkOutput("t6_fresh_ovf", 64'(ovf), 64'b1111);
    drainResult();

    applyStimulus(32'h7F7F7F7F, 32'h80808080, 2'b00, 1'b0, lat);
    checkOutput("t7_wrap_c", 64'(c), 64'hFFFFFFFF);
    checkOutput("t7_wrap_ovf", 64'(ovf), 64'b1111);
    drainResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
